mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 multiplexer path between four requesters.
//   Each requester drives one W input of the shared Mux4to1; this block owns that mux's S select.
//   Ownership is granted one-hot and held while the owner keeps requesting.
//   Sits between the requesting units and the mux, so only one source reaches F per cycle.
// PARAMETERS
//   MAX_HOLD  8   max consecutive grant cycles before forced hand-off (ARB_TIMEOUT_EN only); legal 2..15
//   CNT_W     4   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk     in   1  single clock, all state updates on rising edge
//   rst_n   in   1  asynchronous, active-low reset
//   req     in   4  level request; bit i = requester i wants the mux path
//   gnt     out  4  registered one-hot grant; all-zero when no owner
//   sel     out  2  registered mux select (drives Mux4to1 S); equals index of gnt bit
//   busy    out  1  registered; 1 while any gnt bit is set
//   expire  out  1  registered 1-cycle pulse on a forced hand-off; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset (async, rst_n=0): gnt=4'b0000, sel=2'd0, busy=0, expire=0, ptr=2'd0, hold_cnt=0, state=IDLE.
//   ptr: internal 2-bit priority pointer; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   FSM states:
//     IDLE:  req==0 -> stay. req!=0 -> winner = first set bit in search order; next edge: gnt=1<<winner,
//            sel=winner, busy=1, ptr=winner+1 mod 4, hold_cnt=0, -> GRANT. Latency req->gnt = 1 clock.
//     GRANT: req[sel]=1 (and no forced release) -> hold gnt/sel, hold_cnt++ (saturating).
//            req[sel]=0 -> re-arbitrate same cycle over req (owner bit already 0):
//              other req pending -> next edge grant new winner directly, no bubble cycle, stay GRANT;
//              none pending -> next edge gnt=0, busy=0, -> IDLE; sel keeps last value.
//   Arithmetic: ptr and sel wrap 3 -> 0; hold_cnt never wraps (saturates at 2**CNT_W-1).
//   Requests arriving mid-grant are ignored until owner releases or forced release.
//   Simultaneous requests: ptr order decides; after each grant, the winner becomes lowest priority.
//   gnt never has more than one bit set; sel always matches gnt when busy=1.
//   Reset mid-grant: outputs return to reset values immediately (async), ptr back to 0.
//   Request dropped and re-raised by the same requester in consecutive cycles is a new request (no lock).
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     In GRANT, when hold_cnt == MAX_HOLD-1 and req has another bit set besides the owner, next edge:
//     grant moves to winner by search order from ptr (owner excluded), hold_cnt=0, expire=1 for one cycle.
//     If owner is sole requester at limit -> keep grant, hold_cnt=0, expire=0.
//   ARB_TIMEOUT_EN undefined: no hold counter logic; owner holds indefinitely; expire constant 0.
// TESTING
//   reset with req=4'b1111 held -> gnt=0, sel=0, busy=0 during reset; first edge after release -> gnt=0001, sel=0.
//   req=0100 alone -> after 1 clk gnt=0100, sel=2, busy=1; drop req -> next clk gnt=0000, busy=0, sel stays 2.
//   req=1111 each owner drops after 3 cycles -> grant order 0001,0010,0100,1000,0001; no idle cycle between.
//   owner 0 holds, req=0011; release req[0] -> next clk gnt=0010 (bubble-free hand-off), ptr=2.
//   ARB_TIMEOUT_EN, MAX_HOLD=8: req=0011 held -> gnt=0001 for 8 cycles, then gnt=0010 with expire=1 for 1 cycle.
//   ARB_TIMEOUT_EN, req=0001 only held 20 cycles -> gnt stays 0001, expire never 1; mux F tracks W[sel] throughout.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Purpose : round-robin owner of a shared 4:1 mux select; one-hot grant held while owner requests.
// Latency : 1 clock from req to gnt/sel/busy; owner release re-grants on the next edge with no bubble.
// Backpr. : none; req is a level, non-owners simply wait until the owner drops (or is forced off).
// Build   : define ARB_TIMEOUT_EN to enable the MAX_HOLD forced hand-off and the expire pulse.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       expire
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_busy;

  logic       w_owner_req;
  logic       w_force;
  logic [3:0] w_mask;
  logic       w_found;
  logic [1:0] w_win;

  assign w_owner_req = req[r_sel];

  // A forced hand-off must not pick the current owner again.
  assign w_mask = w_force ? (req & ~r_gnt) : req;

  // Round-robin search starting at r_ptr; lowest offset wins, so scan offsets high to low.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_mask[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_expire;
  logic             w_at_limit;
  logic             w_others;

  assign w_at_limit = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_others   = |(req & ~r_gnt);
  assign w_force    = (r_state == ST_GRANT) && w_owner_req && w_at_limit && w_others;

  // Hold counter restarts on every new grant and at the limit; expire marks forced hand-offs only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_expire   <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if ((r_state == ST_GRANT) && w_owner_req) begin
        if (w_force) begin
          r_hold_cnt <= '0;
          r_expire   <= 1'b1;
        end else if (w_at_limit) begin
          r_hold_cnt <= '0;
        end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign expire = r_expire;
`else
  assign w_force = 1'b0;
  assign expire  = 1'b0;

  // Hold parameters are unused here but kept legal so both builds share one parameter set.
  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_hold_cfg
  end
`endif

  // Grant FSM: idle until a request, hold while the owner requests, re-arbitrate on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_ptr   <= w_win + 2'd1;
          end
        end
        default: begin
          if (w_owner_req && !w_force) begin
            r_state <= ST_GRANT;
          end else if (w_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_ptr   <= w_win + 2'd1;
          end else begin
            // sel deliberately keeps the last owner so the mux path stays stable while idle.
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Purpose : directed scoreboard bench for mux4_rr_arbiter (default build or ARB_TIMEOUT_EN).
// Latency : expectations are queued at the negedge that drives req, checked just after the next posedge.
// Backpr. : none; the monitor pops one expectation per clock whenever the queue is non-empty.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       expire;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       expire;

  exp_t       sb_q[$];
  int         checks;
  int         errors;

  // Bench-side model of the shared mux: each requester drives a distinct W word.
  logic [7:0] w_data [4];
  logic [7:0] f_out;

  assign f_out = w_data[sel];

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .expire (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic ee);
    checks++;
    if (gnt !== eg || sel !== es || busy !== eb || expire !== ee) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b expire=%b, want gnt=%b sel=%0d busy=%b expire=%b",
               name, gnt, sel, busy, expire, eg, es, eb, ee);
    end
    if (eb) begin
      checks++;
      if (f_out !== w_data[es]) begin
        errors++;
        $display("FAIL %s_mux_f: got F=%h want %h", name, f_out, w_data[es]);
      end
    end
  endtask

  task automatic expect_next(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic eb, input logic ee);
    exp_t e;
    e.gnt = eg; e.sel = es; e.busy = eb; e.expire = ee; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step(input string name, input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input logic ee);
    @(negedge clk);
    req = r;
    expect_next(name, eg, es, eb, ee);
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e.name, e.gnt, e.sel, e.busy, e.expire);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    w_data[0] = 8'hA0; w_data[1] = 8'hB1; w_data[2] = 8'hC2; w_data[3] = 8'hD3;
    rst_n = 1'b0;
    req   = 4'b1111;

    // Reset held with all requests up: outputs stay at reset values across edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_next("first_after_reset", 4'b0001, 2'd0, 1'b1, 1'b0);   // ptr -> 1
    step("drop_all_0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2, then release: sel stays 2 while idle.
    step("lone_req2", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);          // ptr -> 3
    step("lone_req2_hold", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("lone_req2_drop", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("idle_sel_kept", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset mid-grant: outputs clear without waiting for a clock edge.
    step("grant_req1", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("async_reset_midgrant", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    expect_next("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);      // ptr = 0

    // All four requesting, each owner drops after 3 cycles: bubble-free rotation.
    step("rr_g0_a", 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_g0_b", 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_g0_c", 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_g1_a", 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_g1_b", 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_g1_c", 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_g2_a", 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_g2_b", 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_g2_c", 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_g3_a", 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_g3_b", 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_g3_c", 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_wrap_g0", 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0);          // ptr -> 1
    step("rr_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 0 holds while 1 waits; release hands straight to 1.
    step("hold_g0", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);            // ptr -> 1
    step("hold_ignore_req1_a", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("hold_ignore_req1_b", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("handoff_to_1", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);       // ptr -> 2
    step("handoff_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Same requester drops and re-raises: treated as a fresh request.
    step("reraise_a", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);          // ptr -> 2
    step("reraise_gap", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("reraise_b", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);          // ptr -> 2
    step("reraise_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Simultaneous 0 and 2 with ptr=2: requester 2 first, then 0.
    step("simul_g2", 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);           // ptr -> 3
    step("simul_g0", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);           // ptr -> 1
    step("simul_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Long contended hold: req=0011 with ptr=1, so requester 1 owns first.
    for (int i = 0; i < 12; i++) begin
`ifdef ARB_TIMEOUT_EN
      if (i < 8)
        step($sformatf("long_hold_%0d", i), 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
      else if (i == 8)
        step("long_hold_expire", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1);
      else
        step($sformatf("long_hold_%0d", i), 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
`else
      step($sformatf("long_hold_%0d", i), 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    step("long_hold_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    step("long_hold_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

    // Sole requester for 20 cycles: never forced off, expire stays low.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sole_hold_%0d", i), 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step("sole_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
